// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Mid-bit sampling needs an exact half period and at least two clocks per half.
  function automatic bit cpb_valid(input int cpb);
    return (cpb >= 4) && ((cpb % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small show-ahead byte FIFO; dout is a register that always holds the head entry
// and keeps the last head once the FIFO drains.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push, do_pop;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign do_pop     = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign dout       = dout_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Next head comes from memory if one remains, else from the incoming byte.
      if (do_pop && (count_reg > (AW+1)'(1)))
        dout_reg <= mem[rd_ptr_inc];
      else if (do_push && (empty || (do_pop && count_reg == (AW+1)'(1))))
        dout_reg <= din;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: two-flop synchroniser, mid-bit sampling FSM, sticky error
// flags and a show-ahead output FIFO.
`timescale 1ns/1ps
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  if (!cpb_valid(CLKS_PER_BIT)) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be even and >= 4");
  end

  rx_state_t                 state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [2:0]                bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                      rx_meta_reg, rx_s_reg;
  logic                      frame_err_reg, overrun_reg;
  logic                      push, set_ferr, set_ovr;
  logic                      fifo_full, fifo_empty, fifo_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign fifo_accept = !fifo_full || (rd_en && !fifo_empty);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    push         = 1'b0;
    set_ferr     = 1'b0;
    set_ovr      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg) state_next = ST_START;
      end
      ST_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s_reg ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shreg_next   = {rx_s_reg, shreg_reg[UART_DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            push       = fifo_accept;
            set_ovr    = !fifo_accept;
            state_next = ST_IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        cnt_next = '0;
        if (rx_s_reg) state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
    // Disabling abandons any frame in flight without raising an error.
    if (!en) begin
      state_next   = ST_IDLE;
      cnt_next     = '0;
      bit_idx_next = '0;
      push         = 1'b0;
      set_ferr     = 1'b0;
      set_ovr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      frame_err_reg <= set_ferr | (frame_err_reg & ~clr_err);
      overrun_reg   <= set_ovr  | (overrun_reg   & ~clr_err);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg_reg),
    .full  (fifo_full),
    .pop   (rd_en),
    .dout  (rd_data),
    .empty (fifo_empty)
  );

  assign rd_valid  = !fifo_empty;
  assign busy      = (state_reg != ST_IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner sequences and
// randomized frames against a queue-based model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       en = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, frame_err, overrun;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .en        (en),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: received bytes in order, last head shown, sticky flags.
  logic [7:0] q[$];
  logic [7:0] last_head = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_valid;
    logic [7:0] exp_head;
    bit         exp_ferr;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    last_head = 8'h00;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : last_head;
    chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() > 0));
    chk({tag, "_data"}, 32'(rd_data), 32'(exp_d));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Drive one 8N1 frame starting at a falling edge of clk. Cycle 154 of the frame
  // is the one whose closing edge carries the stop sample (2 sync flops + IDLE exit
  // + CPB/2 + 9*CPB), so rd_en/clr_err strobes there coincide with the push.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pop_at_push,
                            input bit clr_at_push, input bit chk_lat, input int extra_low);
    logic [9:0] bits;
    bit popped;
    bits = {stop_ok, d, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rx = bits[c / CPB];
      if (pop_at_push) rd_en = (c == 154);
      if (clr_at_push) clr_err = (c == 154);
      @(negedge clk);
      if (chk_lat && c + 1 == 154) chk("latency_pre", 32'(rd_valid), 32'd0);
      if (chk_lat && c + 1 == 155) chk("latency_post", 32'(rd_valid), 32'd1);
    end
    rd_en = 1'b0;
    clr_err = 1'b0;
    if (extra_low > 0) begin
      rx = 1'b0;
      tick(extra_low);
      chk("wait_hi_busy", 32'(busy), 32'd1);
      chk("wait_hi_ferr", 32'(frame_err), 32'd1);
    end
    rx = 1'b1;
    tick(4);
    popped = pop_at_push && (q.size() > 0);
    if (popped) last_head = q.pop_front();
    if (clr_at_push) begin
      m_ferr = 1'b0;
      m_ovr = 1'b0;
    end
    if (!stop_ok)                 m_ferr = 1'b1;
    else if (q.size() < DEPTH)    q.push_back(d);
    else                          m_ovr = 1'b1;
    $display("frame data=%02h stop=%0d pop=%0d clr=%0d fifo=%0d", d, stop_ok, pop_at_push,
             clr_at_push, q.size());
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_pop_data"}, 32'(rd_data), 32'((q.size() > 0) ? q[0] : last_head));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) last_head = q.pop_front();
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1};
    vt[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vt[5] = '{8'h5A, 1'b0, 1'b0, 8'h81, 1'b1};

    tick(3);
    check_state("reset");
    rst_n = 1'b1;
    tick(2);

    // Vector table; first entry also times the push against the start edge.
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].data, vt[i].stop_ok, 1'b0, 1'b0, i == 0, 0);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vt[i].exp_valid));
      chk($sformatf("vec%0d_head", i), 32'(rd_data), 32'(vt[i].exp_head));
      chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vt[i].exp_ferr));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'd0);
      if (vt[i].exp_valid) begin
        pop_one($sformatf("vec%0d", i));
        chk($sformatf("vec%0d_empty", i), 32'(rd_valid), 32'd0);
      end
      clear_err();
    end

    // Short low glitch is rejected at the half-bit start check.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    chk("glitch_busy", 32'(busy), 32'd1);
    tick(6);
    chk("glitch_busy_late", 32'(busy), 32'd1);
    tick(1);
    chk("glitch_idle", 32'(busy), 32'd0);
    tick(4);
    check_state("glitch");

    // Break: bad stop followed by 40 low bit times, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 40 * CPB);
    check_state("break");
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_state("after_break");
    chk("after_break_data", 32'(rd_data), 32'h55);
    clear_err();
    chk("clr_ferr", 32'(frame_err), 32'd0);
    pop_one("after_break");

    // Five frames without pops into a depth-4 FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_state("overrun");
    chk("overrun_flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_order%0d", i), 32'(rd_data), 32'(i));
      pop_one("ovr");
    end
    chk("ovr_drained", 32'(rd_valid), 32'd0);
    clear_err();

    // Full FIFO with a pop on the push cycle: both succeed, no overrun.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check_state("full_pop");
    chk("full_pop_ovr", 32'(overrun), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("full_pop_order%0d", i), 32'(rd_data), 32'(i));
      pop_one("full_pop");
    end

    // en dropped after three data bits of 0xFF.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    chk("en_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tick(1);
    chk("en_idle", 32'(busy), 32'd0);
    tick(3);
    en = 1'b1;
    tick(7 * CPB);
    check_state("en_abort");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_state("en_resume");
    pop_one("en_resume");
    chk("en_single", 32'(rd_valid), 32'd0);

    // Set and clear on the same edge: set wins.
    m_ovr = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("set_wins", 32'(frame_err), 32'd1);
    clear_err();

    // Reset mid-frame with data queued and a flag set.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    rx = 1'b0;
    tick(40);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    tick(3);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(2);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_state("post_reset");
    pop_one("post_reset");

    // Randomized frames, pops and clears against the model.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, $urandom_range(0, 5) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, 1'b0, 0);
      check_state($sformatf("rnd%0d", n));
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_one($sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
